// File: rtl/mt_maint_bank.sv
// Multi-channel MT maintenance register bank. Each channel has a BPI divider, a maintenance clock
// (MC) and a rotating maintenance data field (MDF). mtMR shows the channel selected by mtUNIT.
module mt_maint_bank #(
   parameter int unsigned NCH     = 4,
   parameter int unsigned DIVW    = 12,
   parameter int unsigned DIV6250 = 1050,
   parameter int unsigned DIV1600 = 2047,
   parameter int unsigned DIV800  = 4095
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [35:0]                mtDATAI,
   input  logic                       mtmrWRITE,
   input  logic                       mtGO,
   input  logic [$clog2(NCH)-1:0]     mtUNIT,
   input  logic [8:0]                 mtMDFIN,
   output logic [15:0]                mtMR
);

   localparam int unsigned UW = $clog2(NCH);

   logic                       wr_q;
   logic                       fall_q;
   logic                       ign_q;
   logic [UW-1:0]              pend_q;
   logic                       cap;

   logic [NCH-1:0]             mm_q,   mm_d;
   logic [NCH-1:0][3:0]        mop_q,  mop_d;
   logic [NCH-1:0][1:0]        den_q,  den_d;
   logic [NCH-1:0][DIVW-1:0]   cnt_q,  cnt_d;
   logic [NCH-1:0]             bpi_q,  bpi_d;
   logic [NCH-1:0]             mc_q,   mc_d;
   logic [NCH-1:0][8:0]        mdf_q,  mdf_d;

   logic [NCH-1:0]             sel;
   logic [NCH-1:0]             den_chg;
   logic [NCH-1:0]             tog;

   logic                       unused_bits;
   assign unused_bits = ^{mtDATAI[35:18], mtDATAI[6:5]};

   function automatic logic [DIVW-1:0] reload(input logic [1:0] den);
      logic [DIVW-1:0] r;
      case (den)
         2'd0:    r = DIVW'(DIV6250);
         2'd1:    r = DIVW'(DIV1600);
         2'd2:    r = DIVW'(DIV800);
         default: r = '0;
      endcase
      return r;
   endfunction

   // Only the first high cycle of a strobe captures; ign_q masks a strobe that straddled reset.
   assign cap = mtmrWRITE & ~wr_q & ~ign_q;

   always_comb begin
      mm_d    = mm_q;
      mop_d   = mop_q;
      den_d   = den_q;
      cnt_d   = cnt_q;
      bpi_d   = bpi_q;
      mc_d    = mc_q;
      mdf_d   = mdf_q;
      sel     = '0;
      den_chg = '0;
      tog     = '0;
      for (int i = 0; i < NCH; i++) begin
         sel[i]     = cap && (mtUNIT == UW'(i));
         den_chg[i] = sel[i] && (mtDATAI[17:16] != den_q[i]);
         if (sel[i]) begin
            mm_d[i]  = mtDATAI[0];
            mop_d[i] = mtDATAI[4:1];
            den_d[i] = mtDATAI[17:16];
         end

         if (den_chg[i]) begin
            cnt_d[i] = reload(mtDATAI[17:16]);
            bpi_d[i] = 1'b0;
         end else if (den_q[i] == 2'd3) begin
            cnt_d[i] = '0;
            bpi_d[i] = 1'b0;
         end else if (cnt_q[i] == '0) begin
            cnt_d[i] = reload(den_q[i]);
            bpi_d[i] = ~bpi_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] - DIVW'(1);
         end

         // Write-pulse and free-run sources OR together, so coincident events give one toggle.
         tog[i] = (fall_q && (pend_q == UW'(i)) && mtGO && (mop_q[i] inside {4'd1, 4'd2, 4'd3}))
                  || ((mop_q[i] == 4'd4) && mtGO && bpi_d[i] && !bpi_q[i]);
         mc_d[i] = mc_q[i] ^ tog[i];

         if (sel[i] && mtDATAI[0]) begin
            mdf_d[i] = mtDATAI[15:7];
         end else if (mm_q[i] && mc_d[i] && !mc_q[i]) begin
            mdf_d[i] = {mdf_q[i][7:0], mdf_q[i][8]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q   <= 1'b0;
         fall_q <= 1'b0;
         ign_q  <= mtmrWRITE;
         pend_q <= '0;
         mm_q   <= '0;
         mop_q  <= '0;
         den_q  <= '0;
         bpi_q  <= '0;
         mc_q   <= '0;
         mdf_q  <= '0;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= DIVW'(DIV6250);
         end
      end else begin
         wr_q   <= mtmrWRITE;
         fall_q <= wr_q & ~mtmrWRITE & ~ign_q;
         if (!mtmrWRITE) begin
            ign_q <= 1'b0;
         end
         if (cap) begin
            pend_q <= mtUNIT;
         end
         mm_q  <= mm_d;
         mop_q <= mop_d;
         den_q <= den_d;
         cnt_q <= cnt_d;
         bpi_q <= bpi_d;
         mc_q  <= mc_d;
         mdf_q <= mdf_d;
      end
   end

   always_comb begin
      mtMR = '0;
      for (int i = 0; i < NCH; i++) begin
         if (mtUNIT == UW'(i)) begin
            mtMR = {(mm_q[i] ? mdf_q[i] : mtMDFIN), bpi_q[i], mc_q[i], mop_q[i], mm_q[i]};
         end
      end
   end

endmodule

// File: tb/tb_mt_maint_bank.sv
// Directed bench for mt_maint_bank: reset, write-pulse MC toggle, density, free-run, MDF rotate
// and reset during a strobe.
module tb_mt_maint_bank;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [35:0] mtDATAI = '0;
   logic        mtmrWRITE = 1'b0;
   logic        mtGO = 1'b0;
   logic [1:0]  mtUNIT = '0;
   logic [8:0]  mtMDFIN = 9'h1A5;
   logic [15:0] mtMR;

   int n_chk = 0;
   int n_bad = 0;

   mt_maint_bank dut (
      .clk       (clk),
      .rst       (rst),
      .mtDATAI   (mtDATAI),
      .mtmrWRITE (mtmrWRITE),
      .mtGO      (mtGO),
      .mtUNIT    (mtUNIT),
      .mtMDFIN   (mtMDFIN),
      .mtMR      (mtMR)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   // Strobe high for len cycles; returns in the first low cycle.
   task automatic wr_pulse(input logic [1:0] u, input logic [35:0] d, input int len,
                           input logic g);
      mtUNIT    = u;
      mtDATAI   = d;
      mtGO      = g;
      mtmrWRITE = 1'b1;
      ticks(len);
      mtmrWRITE = 1'b0;
   endtask

   initial begin
      int   n;
      int   cnt;
      logic prev;
      logic found;

      // Reset and BPI period at density 0
      ticks(3);
      rst = 1'b0;
      check("rst_mr", mtMR, 16'hD280);
      ticks(1050);
      check("rst_bpi_1050", {15'd0, mtMR[6]}, 16'd0);
      tick();
      check("rst_bpi_1051", {15'd0, mtMR[6]}, 16'd1);
      ticks(1050);
      check("rst_bpi_2101", {15'd0, mtMR[6]}, 16'd1);
      tick();
      check("rst_bpi_2102", {15'd0, mtMR[6]}, 16'd0);

      // Write-pulse toggle, unit 2, MOP=2, 5-cycle strobe
      wr_pulse(2'd2, 36'h4, 5, 1'b1);
      check("wp_mop", {12'd0, mtMR[4:1]}, 16'd2);
      tick();
      check("wp_mc_early", {15'd0, mtMR[5]}, 16'd0);
      tick();
      check("wp_mc_toggled", {15'd0, mtMR[5]}, 16'd1);
      ticks(5);
      check("wp_mc_single", {15'd0, mtMR[5]}, 16'd1);
      wr_pulse(2'd2, 36'hA, 5, 1'b1);
      check("wp5_mop", {12'd0, mtMR[4:1]}, 16'd5);
      ticks(6);
      check("wp5_no_toggle", {15'd0, mtMR[5]}, 16'd1);
      mtGO = 1'b0;

      // Density change on unit 1
      wr_pulse(2'd1, 36'h10000, 1, 1'b0);
      check("den_clear", {15'd0, mtMR[6]}, 16'd0);
      ticks(1000);
      wr_pulse(2'd1, 36'h10000, 1, 1'b0);
      ticks(1046);
      check("den_bpi_2047", {15'd0, mtMR[6]}, 16'd0);
      tick();
      check("den_bpi_2048", {15'd0, mtMR[6]}, 16'd1);
      wr_pulse(2'd1, 36'h30000, 1, 1'b0);
      cnt = 0;
      for (int i = 0; i < 2200; i++) begin
         if (mtMR[6]) cnt++;
         tick();
      end
      check("den3_stopped", 16'(cnt), 16'd0);

      // Free-run on unit 0
      wr_pulse(2'd0, 36'h8, 1, 1'b1);
      prev  = mtMR[5];
      found = 1'b0;
      for (int i = 0; i < 2300 && !found; i++) begin
         tick();
         if (mtMR[5] != prev) found = 1'b1;
      end
      check("fr_edge", {15'd0, found}, 16'd1);
      check("fr_bpi_rise", {15'd0, mtMR[6]}, 16'd1);
      prev = mtMR[5];
      n = -1;
      for (int i = 1; i <= 2300 && n < 0; i++) begin
         tick();
         if (mtMR[5] != prev) n = i;
      end
      check("fr_period", 16'(n), 16'd2102);
      mtGO = 1'b0;
      prev = mtMR[5];
      cnt  = 0;
      for (int i = 0; i < 2300; i++) begin
         tick();
         if (mtMR[5] != prev) cnt++;
      end
      check("fr_frozen", 16'(cnt), 16'd0);

      // Maintenance MDF on unit 3
      wr_pulse(2'd3, 36'h8083, 2, 1'b0);
      ticks(2);
      check("mdf_load", {7'd0, mtMR[15:7]}, 16'h101);
      check("mdf_ctl", {11'd0, mtMR[5:0] & 6'h1F}, 16'h03);
      wr_pulse(2'd3, 36'h8083, 3, 1'b1);
      ticks(2);
      check("mdf_mc_rise", {15'd0, mtMR[5]}, 16'd1);
      check("mdf_rot", {7'd0, mtMR[15:7]}, 16'h003);
      mtUNIT = 2'd0;
      #1;
      check("mdf_u0_ext", {7'd0, mtMR[15:7]}, 16'h1A5);
      mtMDFIN = 9'h0F0;
      #1;
      check("mdf_u0_comb", {7'd0, mtMR[15:7]}, 16'h0F0);
      mtUNIT = 2'd3;
      #1;
      check("mdf_u3_hold", {7'd0, mtMR[15:7]}, 16'h003);
      tick();
      wr_pulse(2'd3, 36'h8083, 1, 1'b1);
      ticks(2);
      check("mdf_mc_fall", {15'd0, mtMR[5]}, 16'd0);
      check("mdf_reload", {7'd0, mtMR[15:7]}, 16'h101);
      mtGO    = 1'b0;
      mtMDFIN = 9'h1A5;

      // Reset in the middle of a strobe, unit 1, MOP=1
      mtUNIT    = 2'd1;
      mtDATAI   = 36'h2;
      mtGO      = 1'b1;
      mtmrWRITE = 1'b1;
      ticks(2);
      rst = 1'b1;
      ticks(2);
      rst = 1'b0;
      ticks(2);
      mtmrWRITE = 1'b0;
      ticks(4);
      for (int u = 0; u < 4; u++) begin
         mtUNIT = 2'(u);
         #1;
         check($sformatf("rstmid_u%0d", u), mtMR, 16'hD280);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
